// File: rtl/mem_data_arbiter.sv
// Two-master round-robin arbiter with bounded lock for the unified memory data port.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module mem_data_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_MAX   = 4
`ifdef ARB_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_be,
  input  logic [2:0]            m0_load_type,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_be,
  input  logic [2:0]            m1_load_type,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  output logic [2:0]            mem_load_type,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_gnt0,
  output logic [STAT_WIDTH-1:0] stat_gnt1,
  output logic [STAT_WIDTH-1:0] stat_conflict
`endif
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid0_q, rvalid1_q;
  logic             cnt_full;

  assign cnt_full = (cnt_q == CNT_W'(LOCK_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= m0_gnt & ~m0_we;
      rvalid1_q <= m1_gnt & ~m1_we;
    end
  end

  // Grant decision; an exhausted lock yields to a waiting peer
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (m0_req && m1_req) begin
            m0_gnt = ~rr_q;
            m1_gnt = rr_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        S_OWN0: begin
          if (m1_req && cnt_full) m1_gnt = 1'b1;
          else                    m0_gnt = m0_req;
        end
        S_OWN1: begin
          if (m0_req && cnt_full) m0_gnt = 1'b1;
          else                    m1_gnt = m1_req;
        end
        default: ;
      endcase
    end
  end

  // Next-state, round-robin pointer and lock counter
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req && m1_req) rr_d = ~rr_q;
        if (m0_gnt && m0_lock) begin
          state_d = S_OWN0;
          cnt_d   = CNT_W'(1);
        end else if (m1_gnt && m1_lock) begin
          state_d = S_OWN1;
          cnt_d   = CNT_W'(1);
        end
      end
      S_OWN0: begin
        if (m1_gnt) begin
          rr_d    = 1'b0;
          state_d = m1_lock ? S_OWN1 : S_IDLE;
          cnt_d   = m1_lock ? CNT_W'(1) : '0;
        end else if (m0_gnt && m0_lock) begin
          if (!cnt_full) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_OWN1: begin
        if (m0_gnt) begin
          rr_d    = 1'b1;
          state_d = m0_lock ? S_OWN0 : S_IDLE;
          cnt_d   = m0_lock ? CNT_W'(1) : '0;
        end else if (m1_gnt && m1_lock) begin
          if (!cnt_full) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory port mux; idle cycles present all-zero request fields
  always_comb begin
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = '0;
    mem_load_type = '0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    if (m0_gnt) begin
      mem_addr      = m0_addr;
      mem_wdata     = m0_wdata;
      mem_be        = m0_be;
      mem_load_type = m0_load_type;
      mem_we        = m0_we;
      mem_re        = ~m0_we;
    end else if (m1_gnt) begin
      mem_addr      = m1_addr;
      mem_wdata     = m1_wdata;
      mem_be        = m1_be;
      mem_load_type = m1_load_type;
      mem_we        = m1_we;
      mem_re        = ~m1_we;
    end
  end

  // Read returns are suppressed while reset is asserted
  assign m0_rvalid = rvalid0_q & rst;
  assign m1_rvalid = rvalid1_q & rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic [STAT_WIDTH-1:0] st_g0_q, st_g1_q, st_cf_q;
  logic                  waiting;

  assign waiting = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

  // Saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_g0_q <= '0;
      st_g1_q <= '0;
      st_cf_q <= '0;
    end else begin
      if (m0_gnt && (st_g0_q != '1))  st_g0_q <= st_g0_q + STAT_WIDTH'(1);
      if (m1_gnt && (st_g1_q != '1))  st_g1_q <= st_g1_q + STAT_WIDTH'(1);
      if (waiting && (st_cf_q != '1)) st_cf_q <= st_cf_q + STAT_WIDTH'(1);
    end
  end

  assign stat_gnt0     = st_g0_q;
  assign stat_gnt1     = st_g1_q;
  assign stat_conflict = st_cf_q;
`endif

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed and randomized bench for mem_data_arbiter against a transaction-level model.
module tb_mem_data_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk, rst;
  logic        req [2];
  logic        lock[2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wdat[2];
  logic [3:0]  be  [2];
  logic [2:0]  lt  [2];
  logic        gnt [2];
  logic        rvld[2];
  logic [31:0] rdat[2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [2:0]  mem_lt;
  logic        mem_we, mem_re;
`ifdef ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
  int          s_g0, s_g1, s_cf;
`endif

  mem_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdat[0]), .m0_be(be[0]), .m0_load_type(lt[0]),
    .m0_gnt(gnt[0]), .m0_rvalid(rvld[0]), .m0_rdata(rdat[0]),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdat[1]), .m1_be(be[1]), .m1_load_type(lt[1]),
    .m1_gnt(gnt[1]), .m1_rvalid(rvld[1]), .m1_rdata(rdat[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_load_type(mem_lt), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Memory device model, 1-cycle synchronous read
  logic [31:0] dev_mem[logic [31:0]];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
    if (mem_we) dev_mem[mem_addr] = merge(dev_mem.exists(mem_addr) ? dev_mem[mem_addr]
                                          : dflt(mem_addr), mem_wdata, mem_be);
  end

  // Transaction-level reference state
  int          n_cmp, n_bad;
  int          own, rr, cnt;
  bit          pend[2];
  logic [31:0] pend_d[2];
  logic [31:0] ref_mem[logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // One clock: check outputs mid-cycle, advance the model, return the expected winner
  task automatic cycle(output int w);
    @(negedge clk);
    w = -1;
    if (rst) begin
      if (own < 0) begin
        if (req[0] && req[1]) w = rr;
        else if (req[0])      w = 0;
        else if (req[1])      w = 1;
      end else if (req[1-own] && cnt == LOCK_MAX) w = 1 - own;
      else if (req[own])                          w = own;
    end
    chk("gnt0", 32'(gnt[0]), 32'(w == 0));
    chk("gnt1", 32'(gnt[1]), 32'(w == 1));
    chk("mem_we", 32'(mem_we), (w >= 0) ? 32'(we[w]) : 32'd0);
    chk("mem_re", 32'(mem_re), (w >= 0) ? 32'(!we[w]) : 32'd0);
    chk("mem_addr", mem_addr, (w >= 0) ? addr[w] : 32'd0);
    chk("mem_wdata", mem_wdata, (w >= 0) ? wdat[w] : 32'd0);
    chk("mem_be_lt", {25'd0, mem_lt, mem_be}, (w >= 0) ? {25'd0, lt[w], be[w]} : 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rvalid%0d", i), 32'(rvld[i]), 32'(pend[i] && rst));
      if (pend[i] && rst) chk($sformatf("rdata%0d", i), rdat[i], pend_d[i]);
    end
`ifdef ARB_STATS_EN
    chk("stat_gnt0", 32'(stat_gnt0), 32'(s_g0));
    chk("stat_gnt1", 32'(stat_gnt1), 32'(s_g1));
    chk("stat_conflict", 32'(stat_conflict), 32'(s_cf));
    if (!rst) begin
      s_g0 = 0; s_g1 = 0; s_cf = 0;
    end else begin
      if (w == 0 && s_g0 < 65535) s_g0++;
      if (w == 1 && s_g1 < 65535) s_g1++;
      if (((req[0] && w != 0) || (req[1] && w != 1)) && s_cf < 65535) s_cf++;
    end
`endif
    if (!rst) begin
      own = -1; rr = 0; cnt = 0;
      pend[0] = 1'b0; pend[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pend[i] = (w == i) && !we[i];
        if (pend[i]) pend_d[i] = ref_rd(addr[i]);
      end
      if (w >= 0 && we[w]) ref_mem[addr[w]] = merge(ref_rd(addr[w]), wdat[w], be[w]);
      if (own < 0) begin
        if (req[0] && req[1]) rr = 1 - w;
        if (w >= 0 && lock[w]) begin own = w; cnt = 1; end
      end else if (w == own) begin
        if (lock[w]) begin
          if (cnt < LOCK_MAX) cnt++;
        end else begin
          own = -1; cnt = 0;
        end
      end else if (w >= 0) begin
        rr  = own;
        own = lock[w] ? w : -1;
        cnt = lock[w] ? 1 : 0;
      end else begin
        own = -1; cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic r, input logic l, input logic w_e,
                       input logic [31:0] a, input logic [31:0] d);
    req[i] = r; lock[i] = l; we[i] = w_e; addr[i] = a; wdat[i] = d;
    be[i] = 4'hF; lt[i] = 3'(i + 2);
  endtask

  initial begin
    int w;
    int m1_grants;
    n_cmp = 0; n_bad = 0;
    own = -1; rr = 0; cnt = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
`ifdef ARB_STATS_EN
    s_g0 = 0; s_g1 = 0; s_cf = 0;
`endif
    rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    // Reset with both masters requesting
    cycle(w);
    cycle(w);

    // Single m0 read of 0x100
    rst = 1'b1;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(w);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_rvalid0", 32'(rvld[0]), 32'd1);
    chk("t2_rdata0", rdat[0], 32'hDEADBEEF);
    chk("t2_rvalid1", 32'(rvld[1]), 32'd0);
    cycle(w);

    // Both continuous without lock, from reset
    rst = 1'b0;
    cycle(w);
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(w);
      chk("t3_alternate", 32'(w), 32'(k % 2));
    end

    // m1 locks continuously while m0 waits
    rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(w);
    rst = 1'b1;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h110, 32'h0);
    cycle(w);
    m1_grants = (w == 1) ? 1 : 0;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h114, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(w);
      if (w == 1) m1_grants++;
    end
    chk("t4_m1_grants", 32'(m1_grants), 32'd4);
    cycle(w);
    chk("t4_handover", 32'(w), 32'd0);
    cycle(w);
    chk("t4_back_m1", 32'(w), 32'd1);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(w);

    // Write then read back the same address
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h55AA55AA);
    cycle(w);
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    chk("t5_no_rvalid_after_wr", 32'(rvld[0]), 32'd0);
    cycle(w);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_rdata", rdat[0], 32'h55AA55AA);
    cycle(w);

    // Read grant followed by reset
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    cycle(w);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_rvalid_dropped", 32'(rvld[1]), 32'd0);
    cycle(w);
    rst = 1'b1;
    cycle(w);

    // Randomized traffic with held requests and occasional reset
    for (int n = 0; n < 600; n++) begin
      bit done[2];
      done[0] = (w == 0);
      done[1] = (w == 1);
      rst = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || done[i] || $urandom_range(0, 19) == 0) begin
          req[i]  = ($urandom_range(0, 9) < 7);
          lock[i] = $urandom_range(0, 1) == 1;
          we[i]   = $urandom_range(0, 2) == 0;
          addr[i] = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
          wdat[i] = $urandom;
          be[i]   = 4'($urandom_range(0, 15));
          lt[i]   = 3'($urandom_range(0, 7));
        end
      end
      cycle(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
